// File: rtl/timer_pkg.sv
// timer_pkg: constants and types shared by the N-CLIC timer and the core's
// CSR decoder.
//   TIMER_CSR_ADDR : default address of the timer config register; the
//                    counter readback sits at the next address.
//   OFS_*          : bit offsets of the config register fields.
//   timer_state_t  : timer sequencing states.
package timer_pkg;

  localparam logic [11:0] TIMER_CSR_ADDR = 12'h400;

  localparam int OFS_EN      = 0;
  localparam int OFS_ONESHOT = 1;
  localparam int OFS_OVR     = 2;
  localparam int OFS_PRESC   = 4;
  localparam int OFS_CMP     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: PresWidth-bit clock divider for the N-CLIC timer.
//   clk, reset : core clock, asynchronous active-low reset
//   run        : count enable
//   clear      : synchronous clear; wins over counting and suppresses tick
//   limit      : terminal value; tick fires when the count equals it
//   tick       : one-cycle pulse every (limit+1) run cycles
module timer_prescaler #(
  parameter int PresWidth = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 clear,
  input  logic [PresWidth-1:0] limit,
  output logic                 tick
);

  logic [PresWidth-1:0] cnt_q;

  assign tick = run & ~clear & (cnt_q == limit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + PresWidth'(1);
    end
  end

endmodule

// File: rtl/n_clic_timer.sv
// n_clic_timer: periodic CSR-programmable timer that drives one N-CLIC
// interrupt line. Counts prescaled ticks up to a compare value, then raises
// irq_pend until the CLIC acknowledges it.
//   clk, reset            : core clock, asynchronous active-low reset
//   csr_enable/addr/we    : CSR access; config at CsrAddr, counter at CsrAddr+1
//   csr_wdata, csr_rdata  : write data, combinational read data
//   irq_pend, irq_ack     : pending request to the CLIC and its acknowledge
// Build option: define TIMER_ONESHOT_EN to implement the oneshot bit and the
// DONE state; otherwise the timer is always periodic.
//
// state | meaning
// IDLE  | disabled, prescaler and counter hold
// RUN   | counting prescaled ticks toward cmp
// DONE  | one-shot expired, counters held at 0 until the next config write
module n_clic_timer
  import timer_pkg::*;
#(
  parameter logic [11:0] CsrAddr   = TIMER_CSR_ADDR,
  parameter int          CntWidth  = 16,
  parameter int          PresWidth = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        csr_enable,
  input  logic [11:0] csr_addr,
  input  logic        csr_we,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        irq_pend,
  input  logic        irq_ack
);

  localparam logic [11:0] CntAddr = CsrAddr + 12'd1;

  timer_state_t          state_q, state_d;
  logic [PresWidth-1:0]  presc_q;
  logic [CntWidth-1:0]   cmp_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  ovr_q;
  logic                  pend_q;
  logic                  oneshot_q;
  logic                  cfg_wr;
  logic                  run;
  logic                  tick;
  logic                  match;
  logic                  unused_wdata;

  assign cfg_wr = csr_enable & csr_we & (csr_addr == CsrAddr);
  assign run    = (state_q == RUN);
  assign match  = tick & (cnt_q == cmp_q);

  // Field widths depend on parameters, so not every write bit is consumed.
  assign unused_wdata = ^csr_wdata;

  // The prescaler clear also blanks tick, so a config write never coincides
  // with a match.
  timer_prescaler #(
    .PresWidth(PresWidth)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .clear (cfg_wr),
    .limit (presc_q),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      cmp_q   <= '0;
    end else if (cfg_wr) begin
      presc_q <= csr_wdata[OFS_PRESC +: PresWidth];
      cmp_q   <= csr_wdata[OFS_CMP +: CntWidth];
    end
  end

`ifdef TIMER_ONESHOT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oneshot_q <= 1'b0;
    end else if (cfg_wr) begin
      oneshot_q <= csr_wdata[OFS_ONESHOT];
    end
  end
`else
  assign oneshot_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (cfg_wr || match) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  // An event landing together with an ack keeps the request pending and is
  // not an overrun: the CLIC consumed the previous one in that same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (match) begin
        pend_q <= 1'b1;
      end else if (irq_ack) begin
        pend_q <= 1'b0;
      end
      if (cfg_wr) begin
        ovr_q <= 1'b0;
      end else if (match && pend_q && !irq_ack) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign irq_pend = pend_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cfg_wr && csr_wdata[OFS_EN]) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (cfg_wr) begin
          state_d = csr_wdata[OFS_EN] ? RUN : IDLE;
        end else if (match && oneshot_q) begin
          state_d = DONE;
        end
      end
`ifdef TIMER_ONESHOT_EN
      DONE: begin
        if (cfg_wr) begin
          state_d = csr_wdata[OFS_EN] ? RUN : IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // en reads back as "currently running", so an expired one-shot reads 0.
  always_comb begin
    csr_rdata = '0;
    if (csr_addr == CsrAddr) begin
      csr_rdata[OFS_EN]                 = run;
      csr_rdata[OFS_ONESHOT]            = oneshot_q;
      csr_rdata[OFS_OVR]                = ovr_q;
      csr_rdata[OFS_PRESC +: PresWidth] = presc_q;
      csr_rdata[OFS_CMP +: CntWidth]    = cmp_q;
    end else if (csr_addr == CntAddr) begin
      csr_rdata[CntWidth-1:0] = cnt_q;
    end
  end

endmodule
